// File: rtl/matrix_decompiler.sv
// Receive-side frame decoder: hunts for the SYNC0/SYNC1 header and re-emits the payload as addressed
// matrix elements. Define MATRIX_XOR_CHECK_EN to add a trailing XOR checksum byte and a CHECK state.
module matrix_decompiler #(
  parameter int          ROWS           = 32,
  parameter int          COLS           = 32,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                      eth_refclk,
  input  logic                      rst_n,
  input  logic                      valid_data_in,
  input  logic [7:0]                byte_in,
  output logic                      valid_data_out,
  output logic [$clog2(ROWS)-1:0]   row_addr,
  output logic [$clog2(COLS)-1:0]   col_addr,
  output logic [7:0]                matrix_element,
  output logic                      frame_done,
  output logic                      frame_error,
  output logic                      rx_busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

`ifdef MATRIX_XOR_CHECK_EN
  typedef enum logic [1:0] {HUNT, SYNC, PAYLOAD, CHECK} state_t;
  logic [7:0] xor_reg, xor_next;
`else
  typedef enum logic [1:0] {HUNT, SYNC, PAYLOAD} state_t;
`endif

  state_t          state_reg, state_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [IW-1:0]   idle_reg, idle_next;
  logic            vout_reg, vout_next;
  logic [RW-1:0]   row_out_reg, row_out_next;
  logic [CW-1:0]   col_out_reg, col_out_next;
  logic [7:0]      elem_reg, elem_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HUNT;
      row_reg     <= '0;
      col_reg     <= '0;
      idle_reg    <= '0;
      vout_reg    <= 1'b0;
      row_out_reg <= '0;
      col_out_reg <= '0;
      elem_reg    <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef MATRIX_XOR_CHECK_EN
      xor_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      idle_reg    <= idle_next;
      vout_reg    <= vout_next;
      row_out_reg <= row_out_next;
      col_out_reg <= col_out_next;
      elem_reg    <= elem_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
`ifdef MATRIX_XOR_CHECK_EN
      xor_reg     <= xor_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    idle_next    = idle_reg;
    vout_next    = 1'b0;
    row_out_next = row_out_reg;
    col_out_next = col_out_reg;
    elem_next    = elem_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
`ifdef MATRIX_XOR_CHECK_EN
    xor_next     = xor_reg;
`endif

    if (valid_data_in)
      idle_next = '0;
    else if (state_reg != HUNT)
      idle_next = idle_reg + IW'(1);

    case (state_reg)
      HUNT: begin
        if (valid_data_in && byte_in == SYNC0)
          state_next = SYNC;
      end
      SYNC: begin
        if (valid_data_in) begin
          if (byte_in == SYNC1) begin
            state_next = PAYLOAD;
            row_next   = '0;
            col_next   = '0;
`ifdef MATRIX_XOR_CHECK_EN
            xor_next   = '0;
`endif
          end else if (byte_in != SYNC0) begin
            state_next = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (valid_data_in) begin
          vout_next    = 1'b1;
          elem_next    = byte_in;
          row_out_next = row_reg;
          col_out_next = col_reg;
          // Column wraps by natural overflow; the row steps on that wrap.
          col_next     = col_reg + CW'(1);
          if (col_reg == COL_LAST)
            row_next = row_reg + RW'(1);
`ifdef MATRIX_XOR_CHECK_EN
          xor_next = xor_reg ^ byte_in;
`endif
          if (row_reg == ROW_LAST && col_reg == COL_LAST) begin
            row_next = '0;
            col_next = '0;
`ifdef MATRIX_XOR_CHECK_EN
            state_next = CHECK;
`else
            state_next = HUNT;
            done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef MATRIX_XOR_CHECK_EN
      CHECK: begin
        if (valid_data_in) begin
          state_next = HUNT;
          if (byte_in == xor_reg)
            done_next = 1'b1;
          else
            err_next = 1'b1;
        end
      end
`endif
      default: state_next = HUNT;
    endcase

    // A byte arriving on the expiry cycle wins, hence the !valid_data_in term.
    if (!valid_data_in && state_reg != HUNT && idle_reg == IDLE_LAST) begin
      state_next = HUNT;
      row_next   = '0;
      col_next   = '0;
      idle_next  = '0;
      err_next   = 1'b1;
    end
  end

  assign valid_data_out = vout_reg;
  assign row_addr       = row_out_reg;
  assign col_addr       = col_out_reg;
  assign matrix_element = elem_reg;
  assign frame_done     = done_reg;
  assign frame_error    = err_reg;
  assign rx_busy        = (state_reg != HUNT);

endmodule

// File: tb/tb_matrix_decompiler.sv
// Directed-sequence bench for matrix_decompiler with random payloads and a frame-level reference model.
module tb_matrix_decompiler;
  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int N    = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic          eth_refclk = 1'b0;
  logic          rst_n;
  logic          valid_data_in;
  logic [7:0]    byte_in;
  logic          valid_data_out;
  logic [RW-1:0] row_addr;
  logic [CW-1:0] col_addr;
  logic [7:0]    matrix_element;
  logic          frame_done;
  logic          frame_error;
  logic          rx_busy;

  matrix_decompiler #(.ROWS(ROWS), .COLS(COLS)) dut (
    .eth_refclk     (eth_refclk),
    .rst_n          (rst_n),
    .valid_data_in  (valid_data_in),
    .byte_in        (byte_in),
    .valid_data_out (valid_data_out),
    .row_addr       (row_addr),
    .col_addr       (col_addr),
    .matrix_element (matrix_element),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .rx_busy        (rx_busy)
  );

  always #5 eth_refclk = ~eth_refclk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Observation log, written only by the monitor.
  logic [RW+CW+7:0] obs_q[$];
  int done_cnt = 0, done_coinc = 0, done_at = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge eth_refclk) begin
    if (valid_data_out) obs_q.push_back({row_addr, col_addr, matrix_element});
    if (frame_done) begin
      done_cnt++;
      if (valid_data_out) done_coinc++;
      done_at = obs_q.size();
    end
    if (frame_error) err_cnt++;
    if (frame_done && frame_error) both_cnt++;
  end

  logic [7:0] pay[$];
  int b_obs, b_done, b_coinc, b_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_obs = obs_q.size(); b_done = done_cnt; b_coinc = done_coinc; b_err = err_cnt;
  endtask

  task automatic idle(input int n);
    valid_data_in = 1'b0;
    repeat (n) @(negedge eth_refclk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    valid_data_in = 1'b1;
    byte_in       = b;
    @(negedge eth_refclk);
    valid_data_in = 1'b0;
    repeat (gap) @(negedge eth_refclk);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask

  // Full frame from pay[]; under the checksum build a trailing XOR byte follows (optionally corrupted).
  task automatic send_frame(input int gap, input logic corrupt);
    logic [7:0] x;
    x = 8'h00;
    send(8'hA5, gap);
    send(8'h5A, gap);
    foreach (pay[k]) begin
      send(pay[k], gap);
      x ^= pay[k];
    end
`ifdef MATRIX_XOR_CHECK_EN
    send(corrupt ? (x ^ 8'h01) : x, 0);
`else
    if (corrupt) x = 8'h00;
`endif
  endtask

  // Element k of the payload belongs at row k/COLS, column k%COLS.
  task automatic check_elems(input string tag);
    int n;
    logic [RW+CW+7:0] e;
    n = obs_q.size() - b_obs;
    chk({tag, ".count"}, n, pay.size());
    for (int k = 0; k < pay.size() && k < n; k++) begin
      e = {RW'(k / COLS), CW'(k % COLS), pay[k]};
      chk($sformatf("%s.elem%0d", tag, k), obs_q[b_obs + k], e);
    end
  endtask

  task automatic check_good_frame(input string tag);
    check_elems(tag);
    chk({tag, ".done_cnt"}, done_cnt - b_done, 1);
    chk({tag, ".err_cnt"}, err_cnt - b_err, 0);
    chk({tag, ".done_after"}, done_at - b_obs, N);
`ifdef MATRIX_XOR_CHECK_EN
    chk({tag, ".done_with_elem"}, done_coinc - b_coinc, 0);
`else
    chk({tag, ".done_with_elem"}, done_coinc - b_coinc, 1);
`endif
    chk({tag, ".busy"}, rx_busy, 0);
  endtask

  initial begin
    valid_data_in = 1'b0;
    byte_in       = 8'h00;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", valid_data_out, 0);
    chk("rst.row", row_addr, 0);
    chk("rst.col", col_addr, 0);
    chk("rst.elem", matrix_element, 0);
    chk("rst.done", frame_done, 0);
    chk("rst.err", frame_error, 0);
    chk("rst.busy", rx_busy, 0);
    @(negedge eth_refclk);
    @(negedge eth_refclk);
    rst_n = 1'b1;
    idle(2);

    // Clean frame: alternating AA/FF back to back.
    pay.delete();
    for (int k = 0; k < N; k++) pay.push_back((k % 2 == 0) ? 8'hAA : 8'hFF);
    snap();
    send_frame(0, 1'b0);
    idle(3);
    check_good_frame("clean");

    // Hunting through 00, A5, A5, 5A with a random payload.
    rand_pay(N);
    snap();
    send(8'h00, 0);
    send(8'hA5, 0);
    send_frame(0, 1'b0);
    idle(3);
    check_good_frame("hunt");

    // Broken header produces nothing and ends back in HUNT.
    snap();
    send(8'h00, 0); send(8'hA5, 0); send(8'h00, 0); send(8'h5A, 0);
    idle(3);
    chk("badhdr.count", obs_q.size() - b_obs, 0);
    chk("badhdr.busy", rx_busy, 0);
    chk("badhdr.err", err_cnt - b_err, 0);

    // One byte every third cycle.
    rand_pay(N);
    snap();
    send_frame(2, 1'b0);
    idle(3);
    check_good_frame("gappy");

    // Timeout after 100 elements: still busy one cycle before expiry, aborted at it.
    rand_pay(100);
    snap();
    send(8'hA5, 0); send(8'h5A, 0);
    foreach (pay[k]) send(pay[k], 0);
    idle(4095);
    chk("tmo.err_early", err_cnt - b_err, 0);
    chk("tmo.busy_early", rx_busy, 1);
    idle(2);
    check_elems("tmo");
    chk("tmo.err_cnt", err_cnt - b_err, 1);
    chk("tmo.done_cnt", done_cnt - b_done, 0);
    chk("tmo.busy", rx_busy, 0);

    rand_pay(N);
    snap();
    send_frame(0, 1'b0);
    idle(3);
    check_good_frame("after_tmo");

    // A byte landing exactly on the expiry cycle is accepted instead of timing out.
    rand_pay(6);
    snap();
    send(8'hA5, 0); send(8'h5A, 0);
    for (int k = 0; k < 5; k++) send(pay[k], 0);
    idle(4095);
    send(pay[5], 0);
    idle(3);
    chk("edge.err_early", err_cnt - b_err, 0);
    chk("edge.busy_early", rx_busy, 1);
    idle(4100);
    check_elems("edge");
    chk("edge.err_cnt", err_cnt - b_err, 1);
    chk("edge.busy", rx_busy, 0);

    // Asynchronous reset between edges right after element (10,5).
    rand_pay(10 * COLS + 6);
    snap();
    send(8'hA5, 0); send(8'h5A, 0);
    foreach (pay[k]) send(pay[k], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", valid_data_out, 0);
    chk("arst.row", row_addr, 0);
    chk("arst.col", col_addr, 0);
    chk("arst.elem", matrix_element, 0);
    chk("arst.busy", rx_busy, 0);
    @(negedge eth_refclk);
    @(negedge eth_refclk);
    rst_n = 1'b1;
    idle(3);
    check_elems("arst");
    chk("arst.done_cnt", done_cnt - b_done, 0);
    chk("arst.err_cnt", err_cnt - b_err, 0);

    rand_pay(N);
    snap();
    send_frame(0, 1'b0);
    idle(3);
    check_good_frame("after_rst");

`ifdef MATRIX_XOR_CHECK_EN
    pay.delete();
    for (int k = 0; k < N; k++) pay.push_back(8'h01);
    snap();
    send_frame(0, 1'b0);
    idle(3);
    check_good_frame("xor_ok");
    snap();
    send_frame(0, 1'b1);
    idle(3);
    check_elems("xor_bad");
    chk("xor_bad.done_cnt", done_cnt - b_done, 0);
    chk("xor_bad.err_cnt", err_cnt - b_err, 1);
    chk("xor_bad.busy", rx_busy, 0);
`endif

    chk("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/matrix_decompiler.md
Name: matrix_decompiler

Overview:
- Receive-side counterpart of the matrix compiler.
- Consumes the byte stream the compiler emits toward Ethernet: a 2-byte sync header, then ROWS*COLS element bytes in row-major order.
- Re-emits each byte as an addressed matrix element (row, col, value) for the matrix BRAM writer.
- Sits in the eth_refclk domain directly behind the RX byte assembler; frame sync and timeout recovery are handled here.

Parameters:
- ROWS, 32, matrix rows; must be a power of two.
- COLS, 32, matrix columns; must be a power of two.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.
- TIMEOUT_CYCLES, 4096, idle clocks tolerated between bytes inside a frame.

Ports:
- eth_refclk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_data_in  in  1  byte_in valid this cycle; no backpressure.
- byte_in  in  8  received byte.
- valid_data_out  out  1  element outputs valid; one-cycle pulse per element.
- row_addr  out  $clog2(ROWS)  row of the element.
- col_addr  out  $clog2(COLS)  column of the element.
- matrix_element  out  8  element value.
- frame_done  out  1  one-cycle pulse: complete frame delivered.
- frame_error  out  1  one-cycle pulse: frame aborted (timeout, or checksum when enabled).
- rx_busy  out  1  high whenever state is not HUNT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is HUNT; row and col counters are 0; idle counter is 0.
  - All outputs are 0.
  - Reset asserted mid-frame discards the partial frame; no done or error pulse is emitted.
- FSM states: HUNT, SYNC, PAYLOAD (plus CHECK under the optional feature).
- HUNT:
  - Valid byte == SYNC0 -> SYNC.
  - Any other byte is ignored.
- SYNC:
  - Valid byte == SYNC1 -> PAYLOAD, with row=0, col=0.
  - Valid byte == SYNC0 -> stay in SYNC (tolerates a repeated A5).
  - Any other valid byte -> HUNT.
- PAYLOAD, on each accepted byte:
  - Register valid_data_out=1, matrix_element=byte_in, row_addr=row, col_addr=col.
  - Outputs appear the cycle after the byte is accepted (latency 1); outputs hold their values otherwise, and valid_data_out returns to 0.
  - col increments; on col == COLS-1 it wraps to 0 and row increments.
  - The byte at (ROWS-1, COLS-1) is the last element: frame_done pulses in the same cycle as its valid_data_out; state -> HUNT; counters -> 0.
  - Header bytes appearing inside the payload are treated as data, not as resync.
- Timeout:
  - The idle counter clears on every valid_data_in and on entry to HUNT.
  - It increments each cycle without a valid byte while in SYNC, PAYLOAD or CHECK.
  - When it reaches TIMEOUT_CYCLES: frame_error pulses for 1 cycle, state -> HUNT, counters clear. Elements already emitted are not retracted.
  - If a valid byte arrives in the same cycle the count would reach TIMEOUT_CYCLES, the byte wins: it is accepted and no timeout occurs.
- frame_done and frame_error are never high in the same cycle.
- rx_busy is combinational from state.
- Widths: row and col counters are exactly $clog2 wide, so wrap is natural overflow; the last element is detected by comparison, not by overflow.

Optional Feature:
- Macro: MATRIX_XOR_CHECK_EN.
- Defined:
  - After the last element, state -> CHECK instead of HUNT, and frame_done is not raised on the last element.
  - A running XOR of all payload bytes is kept, cleared on entry to PAYLOAD.
  - The next valid byte in CHECK is compared against it. On match, frame_done pulses 1 cycle after that byte. On mismatch, frame_error pulses instead. Either way state -> HUNT.
  - Timeout applies in CHECK.
- Undefined:
  - No CHECK state and no XOR register; frame length is 2 + ROWS*COLS bytes.

Test Plan:
- Clean frame: A5,5A, then 1024 bytes alternating AA,FF, one per clock.
  - Expect 1024 valid_data_out pulses.
  - (0,0)=AA, (0,1)=FF, (31,31)=FF; row increments after col 31.
  - frame_done coincides with the (31,31) pulse; frame_error stays 0.
- Sync hunting: stream 00,A5,A5,5A, then 1024 bytes of 0x11.
  - Frame is accepted; first element (0,0)=11.
  - A stream of 00,A5,00,5A produces no output and returns to HUNT.
- Gappy input: valid_data_in asserted every 3rd cycle through a whole frame.
  - Same addresses and values as the clean frame; no timeout.
- Timeout: send the header plus 100 payload bytes, then go idle for 4096 cycles.
  - 100 elements emitted, last at (3,3).
  - frame_error pulses exactly once; rx_busy drops.
  - A following full frame restarts at (0,0).
- Async reset: drop rst_n mid-payload at element (10,5) between clock edges.
  - All outputs are 0 immediately; no done or error pulse.
  - A subsequent frame decodes normally.
- MATRIX_XOR_CHECK_EN: payload bytes all 0x01 with checksum 00 -> frame_done.
  - The same frame with checksum 01 -> frame_error and no frame_done.
